// File: rtl/axis_delta_pkg.sv
// Shared types and helpers for the AXIS delta splitter.
package axis_delta_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        EMIT
    } state_t;

    // Number of ADDER_WIDTH slices needed to cover a w-bit word.
    function automatic int unsigned slice_count(input int unsigned w, input int unsigned a);
        return (w + a - 1) / a;
    endfunction

endpackage

// File: rtl/axis_delta_splitter_serial_subtractor.sv
// Serial a-b subtractor, ADDER_WIDTH bits per cycle with a registered borrow.
// done_c/neg_c/mag_c are valid in the final slice cycle; mag_c is |a-b|.
module serial_subtractor
    import axis_delta_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = 8,
    parameter int unsigned ADDER_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   en,
    input  logic [TDATA_WIDTH-1:0] a,
    input  logic [TDATA_WIDTH-1:0] b,
    output logic                   done_c,
    output logic                   neg_c,
    output logic [TDATA_WIDTH-1:0] mag_c
);

    localparam int unsigned N  = slice_count(TDATA_WIDTH, ADDER_WIDTH);
    localparam int unsigned PW = N * ADDER_WIDTH;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW = ADDER_WIDTH + 1;

    logic [CW-1:0]          cnt_q;
    logic                   borrow_q;
    logic [PW-1:0]          res_q;
    logic [PW-1:0]          res_d;
    logic [PW-1:0]          a_pad;
    logic [PW-1:0]          b_pad;
    logic [SW-1:0]          slice;
    logic [TDATA_WIDTH-1:0] diff;

    // Zero-extend so a partial top slice needs no special handling.
    assign a_pad = PW'(a);
    assign b_pad = PW'(b);

    always_comb begin
        slice = '0;
        res_d = res_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) begin
                slice = {1'b0, a_pad[i*ADDER_WIDTH +: ADDER_WIDTH]}
                      - {1'b0, b_pad[i*ADDER_WIDTH +: ADDER_WIDTH]}
                      - SW'(borrow_q);
                res_d[i*ADDER_WIDTH +: ADDER_WIDTH] = slice[ADDER_WIDTH-1:0];
            end
        end
    end

    assign done_c = en && (cnt_q == CW'(N - 1));
    assign neg_c  = slice[ADDER_WIDTH];
    assign diff   = res_d[TDATA_WIDTH-1:0];
    assign mag_c  = neg_c ? (~diff + TDATA_WIDTH'(1)) : diff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            res_q    <= '0;
        end else if (start) begin
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            res_q    <= '0;
        end else if (en) begin
            cnt_q    <= cnt_q + CW'(1);
            borrow_q <= slice[ADDER_WIDTH];
            res_q    <= res_d;
        end
    end

endmodule

// File: rtl/axis_delta_splitter.sv
// Splits an AXIS sample stream into add/sub delta streams (d = x[n]-x[n-1], per packet).
// Optional DELTA_PKT_CNT_EN adds a pkt_count output of completed packets.
module axis_delta_splitter
    import axis_delta_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = 8,
    parameter int unsigned ADDER_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_add_tdata,
    output logic                   m_add_tvalid,
    output logic                   m_add_tlast,
    input  logic                   m_add_tready,
    output logic [TDATA_WIDTH-1:0] m_sub_tdata,
    output logic                   m_sub_tvalid,
    output logic                   m_sub_tlast,
    input  logic                   m_sub_tready
`ifdef DELTA_PKT_CNT_EN
    ,
    output logic [31:0]            pkt_count
`endif
);

    state_t                 state_q, state_d;
    logic [TDATA_WIDTH-1:0] x_q, x_d;
    logic [TDATA_WIDTH-1:0] prev_q, prev_d;
    logic [TDATA_WIDTH-1:0] add_data_q, add_data_d;
    logic [TDATA_WIDTH-1:0] sub_data_q, sub_data_d;
    logic                   last_q, last_d;
    logic                   tlast_q, tlast_d;
    logic                   add_valid_q, add_valid_d;
    logic                   sub_valid_q, sub_valid_d;
    logic                   rdy_q, rdy_d;
    logic                   accept_c, start_c, calc_en_c, emit_fin_c;
    logic                   sub_done_c, sub_neg_c;
    logic [TDATA_WIDTH-1:0] sub_mag_c;

    assign accept_c   = (state_q == IDLE) && rdy_q && s_axis_tvalid;
    assign calc_en_c  = (state_q == CALC);
    // A stream is finished once its valid has dropped or it handshakes this cycle.
    assign emit_fin_c = (!add_valid_q || m_add_tready) && (!sub_valid_q || m_sub_tready);

    serial_subtractor #(
        .TDATA_WIDTH(TDATA_WIDTH),
        .ADDER_WIDTH(ADDER_WIDTH)
    ) u_sub (
        .clk   (clk),
        .reset (reset),
        .start (start_c),
        .en    (calc_en_c),
        .a     (x_q),
        .b     (prev_q),
        .done_c(sub_done_c),
        .neg_c (sub_neg_c),
        .mag_c (sub_mag_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c)   state_d = CALC;
            CALC:    if (sub_done_c) state_d = EMIT;
            EMIT:    if (emit_fin_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_d         = x_q;
        last_d      = last_q;
        prev_d      = prev_q;
        add_data_d  = add_data_q;
        sub_data_d  = sub_data_q;
        tlast_d     = tlast_q;
        add_valid_d = add_valid_q;
        sub_valid_d = sub_valid_q;
        start_c     = 1'b0;
        rdy_d       = (state_d == IDLE);
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    x_d     = s_axis_tdata;
                    last_d  = s_axis_tlast;
                    start_c = 1'b1;
                end
            end
            CALC: begin
                if (sub_done_c) begin
                    add_data_d  = sub_neg_c ? '0 : sub_mag_c;
                    sub_data_d  = sub_neg_c ? sub_mag_c : '0;
                    add_valid_d = 1'b1;
                    sub_valid_d = 1'b1;
                    tlast_d     = last_q;
                    prev_d      = last_q ? '0 : x_q;
                end
            end
            EMIT: begin
                if (m_add_tready) add_valid_d = 1'b0;
                if (m_sub_tready) sub_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q         <= '0;
            last_q      <= 1'b0;
            prev_q      <= '0;
            add_data_q  <= '0;
            sub_data_q  <= '0;
            tlast_q     <= 1'b0;
            add_valid_q <= 1'b0;
            sub_valid_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            x_q         <= x_d;
            last_q      <= last_d;
            prev_q      <= prev_d;
            add_data_q  <= add_data_d;
            sub_data_q  <= sub_data_d;
            tlast_q     <= tlast_d;
            add_valid_q <= add_valid_d;
            sub_valid_q <= sub_valid_d;
            rdy_q       <= rdy_d;
        end
    end

`ifdef DELTA_PKT_CNT_EN
    // Counts packets whose tlast beat has completed on both streams.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count <= '0;
        end else if ((state_q == EMIT) && emit_fin_c && tlast_q) begin
            pkt_count <= pkt_count + 32'd1;
        end
    end
`endif

    assign s_axis_tready = rdy_q;
    assign m_add_tdata   = add_data_q;
    assign m_add_tvalid  = add_valid_q;
    assign m_add_tlast   = tlast_q;
    assign m_sub_tdata   = sub_data_q;
    assign m_sub_tvalid  = sub_valid_q;
    assign m_sub_tlast   = tlast_q;

endmodule

// File: tb/tb_axis_delta_splitter.sv
// Scoreboard bench for axis_delta_splitter (W=8/A=4 main instance, W=8/A=3 secondary).
`timescale 1ns/1ps
module tb_axis_delta_splitter;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s_tdata;
    logic       s_tvalid, s_tlast, s_tready;
    logic [7:0] add_tdata, sub_tdata;
    logic       add_tvalid, add_tlast, add_tready;
    logic       sub_tvalid, sub_tlast, sub_tready;
    logic       rnd_rdy, rnd_a, rnd_s, fix_a, fix_s;

    logic [7:0] b_tdata;
    logic       b_tvalid, b_tlast, b_tready;
    logic [7:0] b_add_tdata, b_sub_tdata;
    logic       b_add_tvalid, b_add_tlast, b_sub_tvalid, b_sub_tlast;
    logic       b_rdy;
`ifdef DELTA_PKT_CNT_EN
    logic [31:0] pkt_count, b_pkt_count;
`endif

    beat_t exp_add[$];
    beat_t exp_sub[$];
    int    exp_pkt_last[$];
    int    sum_add_q[$];
    int    sum_sub_q[$];
    int    acc_times[$];
    int    acc_add, acc_sub;
    int    errors, checks, cyc;
    int    add_beats, sub_beats;
    int    prev_x, pkts_sent;

    always #5 clk = ~clk;

    assign add_tready = rnd_rdy ? rnd_a : fix_a;
    assign sub_tready = rnd_rdy ? rnd_s : fix_s;
    assign b_rdy      = 1'b1;

    axis_delta_splitter #(.TDATA_WIDTH(8), .ADDER_WIDTH(4)) u_dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_add_tdata(add_tdata), .m_add_tvalid(add_tvalid), .m_add_tlast(add_tlast), .m_add_tready(add_tready),
        .m_sub_tdata(sub_tdata), .m_sub_tvalid(sub_tvalid), .m_sub_tlast(sub_tlast), .m_sub_tready(sub_tready)
`ifdef DELTA_PKT_CNT_EN
        , .pkt_count(pkt_count)
`endif
    );

    axis_delta_splitter #(.TDATA_WIDTH(8), .ADDER_WIDTH(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tlast(b_tlast), .s_axis_tready(b_tready),
        .m_add_tdata(b_add_tdata), .m_add_tvalid(b_add_tvalid), .m_add_tlast(b_add_tlast), .m_add_tready(b_rdy),
        .m_sub_tdata(b_sub_tdata), .m_sub_tvalid(b_sub_tvalid), .m_sub_tlast(b_sub_tlast), .m_sub_tready(b_rdy)
`ifdef DELTA_PKT_CNT_EN
        , .pkt_count(b_pkt_count)
`endif
    );

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        rnd_a = ($urandom_range(0, 3) != 0);
        rnd_s = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard: handshakes seen here complete on the following rising edge.
    always @(negedge clk) begin
        beat_t e;
        int    d, el;
        if (!reset) begin
            if (s_tvalid && s_tready) acc_times.push_back(cyc);
            if (add_tvalid && add_tready) begin
                add_beats++;
                checks++;
                if (exp_add.size() == 0) begin
                    errors++;
                    $display("FAIL add_unexpected: got data=%0d last=%0b, required no beat", add_tdata, add_tlast);
                end else begin
                    e = exp_add.pop_front();
                    if ({add_tdata, add_tlast} !== e) begin
                        errors++;
                        $display("FAIL add_beat: got data=%0d last=%0b, required data=%0d last=%0b",
                                 add_tdata, add_tlast, e.data, e.last);
                    end
                end
                acc_add += int'(add_tdata);
                if (add_tlast) begin sum_add_q.push_back(acc_add); acc_add = 0; end
            end
            if (sub_tvalid && sub_tready) begin
                sub_beats++;
                checks++;
                if (exp_sub.size() == 0) begin
                    errors++;
                    $display("FAIL sub_unexpected: got data=%0d last=%0b, required no beat", sub_tdata, sub_tlast);
                end else begin
                    e = exp_sub.pop_front();
                    if ({sub_tdata, sub_tlast} !== e) begin
                        errors++;
                        $display("FAIL sub_beat: got data=%0d last=%0b, required data=%0d last=%0b",
                                 sub_tdata, sub_tlast, e.data, e.last);
                    end
                end
                acc_sub += int'(sub_tdata);
                if (sub_tlast) begin sum_sub_q.push_back(acc_sub); acc_sub = 0; end
            end
            if (sum_add_q.size() > 0 && sum_sub_q.size() > 0 && exp_pkt_last.size() > 0) begin
                d  = sum_add_q.pop_front() - sum_sub_q.pop_front();
                el = exp_pkt_last.pop_front();
                checks++;
                if (d != el) begin
                    errors++;
                    $display("FAIL pkt_sum: got sum(add)-sum(sub)=%0d, required %0d", d, el);
                end
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b1;
        exp_add.delete(); exp_sub.delete(); exp_pkt_last.delete();
        sum_add_q.delete(); sum_sub_q.delete();
        acc_add = 0; acc_sub = 0; prev_x = 0; pkts_sent = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] x, input logic last);
        int d, to;
        d = int'(x) - prev_x;
        if (d >= 0) begin
            exp_add.push_back({8'(d), last});
            exp_sub.push_back({8'd0, last});
        end else begin
            exp_add.push_back({8'd0, last});
            exp_sub.push_back({8'(-d), last});
        end
        prev_x = last ? 0 : int'(x);
        if (last) begin exp_pkt_last.push_back(int'(x)); pkts_sent++; end
        s_tdata = x; s_tlast = last; s_tvalid = 1'b1;
        to = 0;
        do begin @(negedge clk); to++; end while (!s_tready && to < 500);
        if (!s_tready) begin
            checks++; errors++;
            $display("FAIL send_timeout: got s_axis_tready=0 after %0d cycles, required 1", to);
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int to;
        to = 0;
        while ((exp_add.size() != 0 || exp_sub.size() != 0) && to < 20000) begin
            @(negedge clk); to++;
        end
        checks++;
        if (exp_add.size() != 0 || exp_sub.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d beats pending, required 0/0", exp_add.size(), exp_sub.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_tready, add_tvalid, sub_tvalid, add_tlast, sub_tlast, add_tdata, sub_tdata} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%0b av=%0b sv=%0b al=%0b sl=%0b ad=%0d sd=%0d, required all 0",
                     s_tready, add_tvalid, sub_tvalid, add_tlast, sub_tlast, add_tdata, sub_tdata);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b0) begin
            errors++; $display("FAIL ready_after_release: got %0b, required 0", s_tready);
        end
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b1) begin
            errors++; $display("FAIL ready_idle: got %0b, required 1", s_tready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int ab, sb;
        ab = add_beats; sb = sub_beats;
        acc_times.delete();
        send(8'd5, 1'b0); send(8'd9, 1'b0); send(8'd3, 1'b1);
        drain();
        checks++;
        if (add_beats - ab != 3 || sub_beats - sb != 3) begin
            errors++; $display("FAIL basic_beats: got add=%0d sub=%0d, required 3/3", add_beats - ab, sub_beats - sb);
        end
        checks++;
        if (acc_times.size() != 3) begin
            errors++; $display("FAIL basic_accepts: got %0d, required 3", acc_times.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (acc_times[i] - acc_times[i-1] != 4) begin
                    errors++; $display("FAIL basic_rate: got %0d clk/sample, required 4", acc_times[i] - acc_times[i-1]);
                end
            end
        end
    endtask

    task automatic test_nondivisible();
        logic [7:0] xs[2];
        logic [7:0] ea[2];
        logic [7:0] es[2];
        int t_acc[2];
        int to;
        xs[0] = 8'd255; xs[1] = 8'd0;
        ea[0] = 8'd255; ea[1] = 8'd0;
        es[0] = 8'd0;   es[1] = 8'd255;
        for (int i = 0; i < 2; i++) begin
            b_tdata = xs[i]; b_tlast = (i == 1); b_tvalid = 1'b1;
            to = 0;
            do begin @(negedge clk); to++; end while (!b_tready && to < 100);
            t_acc[i] = cyc;
            @(posedge clk); #1 b_tvalid = 1'b0;
            to = 0;
            while (!b_add_tvalid && to < 100) begin @(negedge clk); to++; end
            checks++;
            if ({b_add_tvalid, b_sub_tvalid, b_add_tdata, b_sub_tdata, b_add_tlast, b_sub_tlast}
                    !== {1'b1, 1'b1, ea[i], es[i], (i == 1), (i == 1)}) begin
                errors++;
                $display("FAIL nondiv_beat%0d: got av=%0b sv=%0b add=%0d sub=%0d tlast=%0b/%0b, required 1 1 %0d %0d %0b",
                         i, b_add_tvalid, b_sub_tvalid, b_add_tdata, b_sub_tdata, b_add_tlast, b_sub_tlast,
                         ea[i], es[i], (i == 1));
            end
        end
        checks++;
        if (t_acc[1] - t_acc[0] != 5) begin
            errors++; $display("FAIL nondiv_rate: got %0d clk/sample, required 5", t_acc[1] - t_acc[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_packet_restart();
        send(8'd7, 1'b1);
        send(8'd7, 1'b1);
        drain();
    endtask

    task automatic test_backpressure();
        int ab, to;
        send(8'd60, 1'b0);
        drain();
        fix_s = 1'b0;
        ab = add_beats;
        send(8'd20, 1'b1);
        to = 0;
        while (!sub_tvalid && to < 50) begin @(negedge clk); to++; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (sub_tvalid !== 1'b1 || sub_tdata !== 8'd40 || s_tready !== 1'b0 || add_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got sv=%0b sd=%0d rdy=%0b av=%0b, required sv=1 sd=40 rdy=0 av=0",
                         i, sub_tvalid, sub_tdata, s_tready, add_tvalid);
            end
        end
        checks++;
        if (add_beats - ab != 1) begin
            errors++; $display("FAIL bp_add_once: got %0d add beats, required 1", add_beats - ab);
        end
        @(posedge clk); #1 fix_s = 1'b1;
        drain();
    endtask

    task automatic test_reset_mid_calc();
        int beats;
        send(8'd10, 1'b0);
        reset = 1'b1;
        exp_add.delete(); exp_sub.delete(); exp_pkt_last.delete();
        sum_add_q.delete(); sum_sub_q.delete();
        acc_add = 0; acc_sub = 0; prev_x = 0; pkts_sent = 0;
        beats = add_beats + sub_beats;
        @(negedge clk);
        checks++;
        if (add_tvalid !== 1'b0 || sub_tvalid !== 1'b0 || s_tready !== 1'b0) begin
            errors++;
            $display("FAIL midcalc_reset: got av=%0b sv=%0b rdy=%0b, required 0 0 0", add_tvalid, sub_tvalid, s_tready);
        end
        @(posedge clk); #1 reset = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (add_beats + sub_beats != beats || add_tvalid !== 1'b0 || sub_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL midcalc_no_beat: got %0d beats av=%0b sv=%0b, required 0 beats and no valid",
                     add_beats + sub_beats - beats, add_tvalid, sub_tvalid);
        end
        @(posedge clk); #1;
        send(8'd4, 1'b1);
        drain();
    endtask

    task automatic test_random();
        int len;
        apply_reset();
        rnd_rdy = 1'b1;
        for (int p = 0; p < 512; p++) begin
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                send(8'($urandom_range(0, 255)), (k == len - 1));
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 2)) @(posedge clk);
                    #1;
                end
            end
        end
        drain();
        rnd_rdy = 1'b0;
        checks++;
        if (exp_pkt_last.size() != 0) begin
            errors++; $display("FAIL random_pkts: got %0d packets unchecked, required 0", exp_pkt_last.size());
        end
`ifdef DELTA_PKT_CNT_EN
        checks++;
        if (pkt_count !== 32'(pkts_sent)) begin
            errors++; $display("FAIL pkt_count: got %0d, required %0d", pkt_count, pkts_sent);
        end
`endif
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0;
        add_beats = 0; sub_beats = 0; acc_add = 0; acc_sub = 0;
        prev_x = 0; pkts_sent = 0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        b_tdata = '0; b_tvalid = 1'b0; b_tlast = 1'b0;
        rnd_rdy = 1'b0; rnd_a = 1'b1; rnd_s = 1'b1; fix_a = 1'b1; fix_s = 1'b1;
        reset = 1'b1;
        test_reset();
        test_basic();
        test_nondivisible();
        test_packet_restart();
        test_backpressure();
        test_reset_mid_calc();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
